// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter: holds a one-hot grant across accepts, rotating
// after WEIGHT accepts or when the owner withdraws, with back-to-back regrant.
module wrr_arbiter #(
    parameter int N        = 4,
    parameter int WEIGHT_W = 4,
    parameter int IDX_W    = $clog2(N)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N-1:0]          req,
    input  logic [N*WEIGHT_W-1:0] weight,
    input  logic                  accept,
    output logic [N-1:0]          grant,
    output logic                  grant_valid,
    output logic [IDX_W-1:0]      grant_idx,
    output logic [WEIGHT_W-1:0]   credit
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t              state_q;
    logic [IDX_W-1:0]    ptr_q;
    logic [N-1:0]        grant_q;
    logic [IDX_W-1:0]    idx_q;
    logic [WEIGHT_W-1:0] credit_q;

    logic [N-1:0]        reqMasked;
    logic [IDX_W-1:0]    firstMasked;
    logic [IDX_W-1:0]    firstReq;
    logic [IDX_W-1:0]    selIdx;
    logic [WEIGHT_W-1:0] selWeight;
    logic [WEIGHT_W-1:0] loadCredit;
    logic                endTurn;

    // ptr always equals the last owner, so one search serves both IDLE and BUSY.
    always_comb begin
        reqMasked   = '0;
        firstMasked = '0;
        firstReq    = '0;
        for (int i = 0; i < N; i++) begin
            reqMasked[i] = req[i] && (i > int'(ptr_q));
        end
        for (int i = N - 1; i >= 0; i--) begin
            if (reqMasked[i]) firstMasked = IDX_W'(i);
            if (req[i])       firstReq    = IDX_W'(i);
        end
        selIdx     = (|reqMasked) ? firstMasked : firstReq;
        selWeight  = weight[int'(selIdx)*WEIGHT_W +: WEIGHT_W];
        loadCredit = (selWeight == '0) ? WEIGHT_W'(1) : selWeight;
        endTurn    = (state_q == IDLE)
                   || (accept && (credit_q <= WEIGHT_W'(1)))
                   || (!accept && !req[idx_q]);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            ptr_q    <= IDX_W'(N - 1);
            grant_q  <= '0;
            idx_q    <= '0;
            credit_q <= '0;
        end else if (endTurn) begin
            if (|req) begin
                state_q  <= BUSY;
                ptr_q    <= selIdx;
                grant_q  <= {{(N-1){1'b0}}, 1'b1} << selIdx;
                idx_q    <= selIdx;
                credit_q <= loadCredit;
            end else begin
                state_q  <= IDLE;
                grant_q  <= '0;
                idx_q    <= '0;
                credit_q <= '0;
            end
        end else if (accept) begin
            credit_q <= credit_q - WEIGHT_W'(1);
        end
    end

    assign grant       = grant_q;
    assign grant_valid = (state_q == BUSY);
    assign grant_idx   = idx_q;
    assign credit      = credit_q;

endmodule

// File: tb/tb_wrr_arbiter.sv
// Self-checking bench for wrr_arbiter: a behavioural model feeds a scoreboard
// queue each cycle, with directed index/credit checks layered on top.
module tb_wrr_arbiter;

    localparam int N = 4;

    logic        clk;
    logic        reset;
    logic [3:0]  req;
    logic [15:0] weightBus;
    logic        accept;
    logic [3:0]  grant;
    logic        grant_valid;
    logic [1:0]  grant_idx;
    logic [3:0]  credit;

    logic [3:0]  wts [4];

    typedef struct {
        logic [3:0] grant;
        logic       valid;
        logic [1:0] idx;
        logic [3:0] credit;
    } expect_t;

    expect_t sbQueue[$];

    int checkCount = 0;
    int errorCount = 0;

    int mBusy;
    int mPtr;
    int mIdx;
    int mCredit;

    assign weightBus = {wts[3], wts[2], wts[1], wts[0]};

    wrr_arbiter #(.N(4), .WEIGHT_W(4)) dut (
        .clk(clk),
        .reset(reset),
        .req(req),
        .weight(weightBus),
        .accept(accept),
        .grant(grant),
        .grant_valid(grant_valid),
        .grant_idx(grant_idx),
        .credit(credit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    function automatic int modelSel(input int p, input logic [3:0] r);
        for (int k = 1; k <= N; k++) begin
            int j;
            j = (p + k) % N;
            if (r[j]) return j;
        end
        return -1;
    endfunction

    task automatic modelReset();
        mBusy   = 0;
        mPtr    = N - 1;
        mIdx    = 0;
        mCredit = 0;
    endtask

    task automatic modelLoad(input int s);
        mBusy   = 1;
        mIdx    = s;
        mPtr    = s;
        mCredit = (wts[s] == 4'd0) ? 1 : int'(wts[s]);
    endtask

    task automatic modelStep(input logic [3:0] r, input logic a);
        int s;
        if (mBusy == 0) begin
            s = modelSel(mPtr, r);
            if (s >= 0) modelLoad(s);
        end else if (a && mCredit > 1) begin
            mCredit = mCredit - 1;
        end else if (a || !r[mIdx]) begin
            s = modelSel(mIdx, r);
            if (s >= 0) modelLoad(s);
            else begin
                mBusy   = 0;
                mIdx    = 0;
                mCredit = 0;
            end
        end
    endtask

    // Drive one cycle; expIdx/expCredit of -1 skip the directed comparison.
    task automatic applyStimulus(input logic [3:0] r, input logic a, input int expIdx, input int expCredit);
        expect_t e;
        expect_t got;
        req    = r;
        accept = a;
        modelStep(r, a);
        e.valid  = (mBusy != 0);
        e.grant  = (mBusy != 0) ? (4'b0001 << mIdx) : 4'b0000;
        e.idx    = 2'(mIdx);
        e.credit = 4'(mCredit);
        sbQueue.push_back(e);
        @(posedge clk);
        #1;
        got = sbQueue.pop_front();
        checkOutput("sbGrant", 32'(grant), 32'(got.grant));
        checkOutput("sbValid", 32'(grant_valid), 32'(got.valid));
        checkOutput("sbIdx", 32'(grant_idx), 32'(got.idx));
        checkOutput("sbCredit", 32'(credit), 32'(got.credit));
        if (expIdx >= 0) checkOutput("dirIdx", 32'(grant_idx), 32'(expIdx));
        if (expCredit >= 0) checkOutput("dirCredit", 32'(credit), 32'(expCredit));
    endtask

    task automatic doReset();
        reset  = 1'b1;
        req    = '0;
        accept = 1'b0;
        modelReset();
        @(posedge clk);
        #1;
        checkOutput("resetGrant", 32'(grant), 32'd0);
        checkOutput("resetValid", 32'(grant_valid), 32'd0);
        checkOutput("resetCredit", 32'(credit), 32'd0);
        reset = 1'b0;
    endtask

    initial begin
        reset  = 1'b1;
        req    = '0;
        accept = 1'b0;
        for (int i = 0; i < N; i++) wts[i] = 4'd1;
        modelReset();
        @(posedge clk);
        doReset();

        for (int i = 0; i < 5; i++) applyStimulus(4'b0000, 1'b0, 0, 0);

        begin
            int seq[6] = '{0, 1, 2, 3, 0, 1};
            for (int i = 0; i < 6; i++) applyStimulus(4'b1111, 1'b1, seq[i], 1);
        end
        applyStimulus(4'b0000, 1'b0, 0, 0);

        doReset();
        wts[0] = 4'd1; wts[1] = 4'd3; wts[2] = 4'd2; wts[3] = 4'd1;
        begin
            int seqIdx[8] = '{0, 1, 1, 1, 2, 2, 3, 0};
            int seqCr[8]  = '{1, 3, 2, 1, 2, 1, 1, 1};
            for (int i = 0; i < 8; i++) applyStimulus(4'b1111, 1'b1, seqIdx[i], seqCr[i]);
        end
        applyStimulus(4'b0000, 1'b0, 0, 0);

        doReset();
        wts[3] = 4'd3;
        applyStimulus(4'b0100, 1'b0, 2, 2);
        applyStimulus(4'b1001, 1'b0, 3, 3);
        checkOutput("withdrawGrant", 32'(grant), 32'h8);
        applyStimulus(4'b0000, 1'b0, 0, 0);

        wts[1] = 4'd2;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(4'b0010, 1'b1, 1, 2);
            applyStimulus(4'b0010, 1'b1, 1, 1);
        end
        applyStimulus(4'b0000, 1'b0, 0, 0);

        wts[3] = 4'd2;
        applyStimulus(4'b1000, 1'b0, 3, 2);
        reset = 1'b1;
        modelReset();
        #1;
        checkOutput("asyncGrant", 32'(grant), 32'd0);
        checkOutput("asyncValid", 32'(grant_valid), 32'd0);
        checkOutput("asyncIdx", 32'(grant_idx), 32'd0);
        checkOutput("asyncCredit", 32'(credit), 32'd0);
        reset = 1'b0;
        wts[0] = 4'd0;
        wts[1] = 4'd15;
        applyStimulus(4'b1111, 1'b0, 0, 1);
        applyStimulus(4'b1111, 1'b1, 1, 15);
        wts[1] = 4'd3;
        for (int k = 14; k >= 1; k--) applyStimulus(4'b1111, 1'b1, 1, k);
        applyStimulus(4'b1111, 1'b1, 2, 2);

        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 7) == 0) wts[$urandom_range(0, 3)] = 4'($urandom_range(0, 15));
            applyStimulus(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), -1, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
